mac_out_fifo: RTL and testbench

- Downstream stage of the square-accumulate MAC. Consumes its 20-bit accumulated result `f` and the associated `valid_out` strobe.
- Buffers each valid result in a small synchronous FIFO and hands results onward over a valid/ready handshake.
- Absorbs back-pressure that the MAC cannot tolerate, since the MAC has no stall input.
- Records any result dropped because the FIFO was full.

---
 rtl/mac_out_fifo.sv | 75 +++++++
 tb/tb_mac_out_fifo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_out_fifo.sv
// Output buffer for the square-accumulate MAC: show-ahead FIFO with valid/ready drain and a sticky overflow flag.
// Optional MAC_OUT_FIFO_PEAK_EN adds a running-maximum `peak` port over accepted results.
module mac_out_fifo #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] f_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              overflow
`ifdef MAC_OUT_FIFO_PEAK_EN
    ,
    output logic [DATA_W-1:0] peak
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic              drop;

    // Outputs depend only on registered state, never on ready_in/valid_in.
    assign valid_out = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign data_out  = valid_out ? mem[rd_ptr] : '0;

    assign pop  = valid_out && ready_in;
    assign push = valid_in && (!full || pop);
    assign drop = valid_in && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; valid_out masks stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= f_in;
    end

`ifdef MAC_OUT_FIFO_PEAK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak <= '0;
        end else if (push && (f_in > peak)) begin
            peak <= f_in;
        end
    end
`endif

endmodule

// File: tb/tb_mac_out_fifo.sv
// Scenario bench for mac_out_fifo: a queue model tracks accepted results and is popped as the DUT drains.
// Peak checks are compiled in when MAC_OUT_FIFO_PEAK_EN is defined.
module tb_mac_out_fifo;

    localparam int DATA_W = 20;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] f_in;
    logic              valid_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ready_in;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              overflow;
`ifdef MAC_OUT_FIFO_PEAK_EN
    logic [DATA_W-1:0] peak;
`endif

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] q[$];
    logic              m_ovf;
    logic [DATA_W-1:0] m_peak;

    mac_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .f_in      (f_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
`ifdef MAC_OUT_FIFO_PEAK_EN
        ,
        .peak      (peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and update the model from the inputs driven before it.
    task automatic tick();
        logic              mpop;
        logic              mpush;
        logic [DATA_W-1:0] fv;
        fv    = f_in;
        mpop  = (q.size() != 0) && ready_in;
        mpush = valid_in && ((q.size() != DEPTH) || mpop);
        if (valid_in && !mpush) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        if (mpop) void'(q.pop_front());
        if (mpush) begin
            q.push_back(fv);
            if (fv > m_peak) m_peak = fv;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        f_in     = '0;
        q.delete();
        m_ovf  = 1'b0;
        m_peak = '0;
        #2;
        checks++;
        if (valid_out !== 1'b0 || count !== '0 || overflow !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid_out=%0b count=%0d overflow=%0b full=%0b, want 0 0 0 0",
                     valid_out, count, overflow, full);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b0 || data_out !== '0 || count !== '0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL idle_%0d: valid_out=%0b data_out=%0d count=%0d overflow=%0b, want 0 0 0 0",
                         i, valid_out, data_out, count, overflow);
            end
        end
    endtask

    task automatic test_single();
        valid_in = 1'b1;
        f_in     = DATA_W'(441);
        ready_in = 1'b1;
        tick();
        valid_in = 1'b0;
        f_in     = DATA_W'(12345);
        checks++;
        if (valid_out !== 1'b1 || q.size() != 1 || data_out !== q[0]) begin
            errors++;
            $display("FAIL single_out: valid_out=%0b data_out=%0d, want 1 441", valid_out, data_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0 || count !== '0 || data_out !== '0) begin
            errors++;
            $display("FAIL single_drained: valid_out=%0b count=%0d data_out=%0d, want 0 0 0",
                     valid_out, count, data_out);
        end
    endtask

    task automatic test_fill_drain();
        logic [DATA_W-1:0] vals [8];
        vals = '{441, 1737, 5833, 70858, 74954, 1, 2, 3};
        ready_in = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f_in = vals[i];
            tick();
        end
        valid_in = 1'b0;
        checks++;
        if (count !== CNT_W'(DEPTH) || full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_state: count=%0d full=%0b overflow=%0b, want 8 1 0", count, full, overflow);
        end
`ifdef MAC_OUT_FIFO_PEAK_EN
        checks++;
        if (peak !== m_peak || peak !== DATA_W'(74954)) begin
            errors++;
            $display("FAIL fill_peak: peak=%0d, want 74954", peak);
        end
`endif
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (valid_out !== 1'b1 || q.size() == 0 || data_out !== q[0]) begin
                errors++;
                $display("FAIL drain_%0d: valid_out=%0b data_out=%0d, want 1 %0d",
                         i, valid_out, data_out, vals[i]);
            end
            tick();
        end
        checks++;
        if (valid_out !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL drain_empty: valid_out=%0b count=%0d, want 0 0", valid_out, count);
        end
    endtask

    task automatic test_overflow();
        ready_in = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f_in = DATA_W'(200 + i);
            tick();
        end
        f_in = DATA_W'(99);
        tick();
        checks++;
        if (overflow !== 1'b1 || count !== CNT_W'(DEPTH) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow_drop: overflow=%0b count=%0d, want 1 8", overflow, count);
        end
        f_in     = DATA_W'(100);
        ready_in = 1'b1;
        checks++;
        if (data_out !== q[0]) begin
            errors++;
            $display("FAIL overflow_head: data_out=%0d, want %0d", data_out, q[0]);
        end
        tick();
        valid_in = 1'b0;
        checks++;
        if (count !== CNT_W'(DEPTH) || full !== 1'b1) begin
            errors++;
            $display("FAIL push_while_full_pop: count=%0d full=%0b, want 8 1", count, full);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (valid_out !== 1'b1 || q.size() == 0 || data_out !== q[0] || data_out === DATA_W'(99)) begin
                errors++;
                $display("FAIL overflow_drain_%0d: data_out=%0d, want %0d", i, data_out,
                         (q.size() != 0) ? q[0] : '0);
            end
            tick();
        end
        checks++;
        if (valid_out !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: valid_out=%0b overflow=%0b, want 0 1", valid_out, overflow);
        end
    endtask

    task automatic test_back_to_back();
        ready_in = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_in = DATA_W'(1000 + i);
            tick();
        end
        ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            f_in = DATA_W'(1003 + i);
            checks++;
            if (valid_out !== 1'b1 || data_out !== q[0] || data_out !== DATA_W'(1000 + i)) begin
                errors++;
                $display("FAIL b2b_data_%0d: data_out=%0d, want %0d", i, data_out, 1000 + i);
            end
            tick();
            checks++;
            if (count !== CNT_W'(3)) begin
                errors++;
                $display("FAIL b2b_count_%0d: count=%0d, want 3", i, count);
            end
        end
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_out !== q[0]) begin
                errors++;
                $display("FAIL b2b_tail_%0d: data_out=%0d, want %0d", i, data_out, q[0]);
            end
            tick();
        end
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: valid_out=%0b, want 0", valid_out);
        end
    endtask

    task automatic test_async_reset();
        ready_in = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f_in = DATA_W'(500 + i);
            tick();
        end
        valid_in = 1'b0;
        checks++;
        if (count !== CNT_W'(5) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: count=%0d overflow=%0b, want 5 1", count, overflow);
        end
        reset = 1'b0;
        #2;
        q.delete();
        m_ovf  = 1'b0;
        m_peak = '0;
        checks++;
        if (count !== '0 || valid_out !== 1'b0 || overflow !== 1'b0 || data_out !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d valid_out=%0b overflow=%0b data_out=%0d, want 0 0 0 0",
                     count, valid_out, overflow, data_out);
        end
`ifdef MAC_OUT_FIFO_PEAK_EN
        checks++;
        if (peak !== '0) begin
            errors++;
            $display("FAIL async_reset_peak: peak=%0d, want 0", peak);
        end
`endif
        @(posedge clk);
        #1;
        reset    = 1'b1;
        valid_in = 1'b1;
        ready_in = 1'b1;
        f_in     = DATA_W'(7);
        tick();
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b1 || data_out !== q[0] || count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL post_reset_push: valid_out=%0b data_out=%0d count=%0d, want 1 7 1",
                     valid_out, data_out, count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
